fetch_ctrl: RTL

Instruction fetch and program-flow controller for the 14-bit MCU core. It owns the program counter that drives the program ROM address, and registers the returned 14-bit instruction into the instruction register for the execute stage. It resolves CALL, GOTO, RETURN, RETLW, computed-PC writes and skip requests through an internal circular return stack. Two-stage fetch/execute with one-slot flush on every taken redirect.

---
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch/execute boundary: program ROM port, execute-stage controls and stack status.
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 11
);
    logic [13:0]       rom_data_in;
    logic              skip_req;
    logic              pcl_load;
    logic [ADDR_W-1:0] pcl_value;
    logic [ADDR_W-1:0] rom_addr_out;
    logic [13:0]       ir_out;
    logic              retlw_valid;
    logic [7:0]        retlw_k;
    logic              flush;
    logic [3:0]        stack_level;
    logic              stack_ovf;
    logic              stack_unf;

    // Fetch controller side
    modport slave (
        input  rom_data_in, skip_req, pcl_load, pcl_value,
        output rom_addr_out, ir_out, retlw_valid, retlw_k, flush,
               stack_level, stack_ovf, stack_unf
    );

    // Core / ROM side
    modport master (
        output rom_data_in, skip_req, pcl_load, pcl_value,
        input  rom_addr_out, ir_out, retlw_valid, retlw_k, flush,
               stack_level, stack_ovf, stack_unf
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch and program-flow controller: PC, instruction register and
// circular return stack for the 14-bit MCU core.
module fetch_ctrl #(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned STACK_DEPTH  = 8,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.slave  bus
);
    localparam int unsigned IR_W  = 14;
    localparam int unsigned SP_W  = $clog2(STACK_DEPTH);
    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
    localparam logic [IR_W-1:0] OP_NOP    = 14'h0000;
    localparam logic [IR_W-1:0] OP_RETURN = 14'h0008;

    logic [ADDR_W-1:0] r_pc;
    logic [IR_W-1:0]   r_ir;
    logic [SP_W-1:0]   r_sp;
    logic [LVL_W-1:0]  r_level;
    logic              r_ovf;
    logic              r_unf;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    logic              w_is_call;
    logic              w_is_goto;
    logic              w_is_ret;
    logic              w_is_retlw;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_pop_addr;
    logic [SP_W-1:0]   w_sp_dec;
    logic [IR_W-1:0]   w_ir_nxt;
    logic              w_full;
    logic              w_empty;

    // Decode the executing instruction and locate the top-of-stack entry
    always_comb begin
        w_is_call  = (r_ir[13:11] == 3'b100);
        w_is_goto  = (r_ir[13:11] == 3'b101);
        w_is_ret   = (r_ir == OP_RETURN);
        w_is_retlw = (r_ir[13:10] == 4'b1101);
        w_pc_inc   = r_pc + ADDR_W'(1);
        w_sp_dec   = r_sp - SP_W'(1);
        w_pop_addr = r_stack[w_sp_dec];
        w_full     = (r_level == LVL_W'(STACK_DEPTH));
        w_empty    = (r_level == LVL_W'(0));
    end

    // Next-PC selection by priority; any redirect squashes the slot being fetched
    always_comb begin
        w_pc_nxt = w_pc_inc;
        w_flush  = 1'b0;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        if (w_is_call || w_is_goto) begin
            w_pc_nxt = ADDR_W'(r_ir[10:0]);
            w_flush  = 1'b1;
            w_push   = w_is_call;
        end else if (w_is_ret || w_is_retlw) begin
            w_pc_nxt = w_pop_addr;
            w_flush  = 1'b1;
            w_pop    = 1'b1;
        end else if (bus.pcl_load) begin
            w_pc_nxt = bus.pcl_value;
            w_flush  = 1'b1;
        end else if (bus.skip_req) begin
            w_flush  = 1'b1;
        end
        w_ir_nxt = w_flush ? OP_NOP : bus.rom_data_in;
    end

    // PC, IR, stack pointer, occupancy and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= ADDR_W'(RESET_VECTOR);
            r_ir    <= OP_NOP;
            r_sp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            r_ir <= w_ir_nxt;
            if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_level <= r_level + LVL_W'(1);
                end
            end else if (w_pop) begin
                r_sp <= w_sp_dec;
                if (w_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_level <= r_level - LVL_W'(1);
                end
            end
        end
    end

    // Return-address storage; contents survive reset, a full push overwrites the oldest
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_sp] <= r_pc;
        end
    end

    assign bus.rom_addr_out = r_pc;
    assign bus.ir_out       = r_ir;
    assign bus.retlw_valid  = w_is_retlw;
    assign bus.retlw_k      = r_ir[7:0];
    assign bus.flush        = w_flush;
    assign bus.stack_level  = 4'(r_level);
    assign bus.stack_ovf    = r_ovf;
    assign bus.stack_unf    = r_unf;
endmodule
